elevator_scheduler: RTL and testbench
=====================================

Name: elevator_scheduler

Overview:
Collective-control scheduler for the 4-floor elevator. It latches floor calls into a pending set and picks the motor direction by SCAN order, serving calls on the way. It also sequences the door dwell timer and handles obstruction, emergency stop and sensor faults. It sits between the debounced button/sensor inputs and the motor/HEX display encoders.

Parameters:
N_FLOORS, 4, number of floors; one sensor bit and one call bit per floor; floor numbers run 1..N_FLOORS.
DOOR_TICKS, 8, number of clk cycles the door stays open after the last reload; counter width is clog2(DOOR_TICKS+1).

Ports:
clk  input  1  system clock; all state is updated on the rising edge.
rst_n  input  1  asynchronous active-low reset.
call_req  input  N_FLOORS  active-high call per floor (top level drives ~KEY); a level is accepted on every cycle.
floor_sensor  input  N_FLOORS  one-hot floor-present sensor; 0 means between floors.
door_obstruct  input  1  active-high obstruction (SW[4]).
emergency_stop  input  1  active-high emergency stop (SW[5]).
motor  output  2  00 stop, 01 up, 10 down; 11 is never driven.
door_open  output  1  door open command.
current_floor  output  3  last valid floor, 1..N_FLOORS.
target_floor  output  3  floor being headed to; 0 means none.
pending  output  N_FLOORS  latched unserved calls.
fault  output  1  sticky sensor fault flag.

Behaviour:
- Reset (async assert, sync release). All outputs registered.
  - state=IDLE, motor=00, door_open=0.
  - current_floor=1, target_floor=0, pending=0, fault=0, dir_up=1.
- Floor tracking:
  - floor_sensor exactly one-hot: current_floor <= index+1.
  - floor_sensor==0: current_floor holds.
  - More than one bit set: enter FAULT.
- Call latching: pending <= pending | call_req each cycle. Exceptions:
  - In DOOR_OPEN, a call for current_floor is not latched; it reloads the door timer.
  - In FAULT, calls are not latched.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ESTOP, FAULT.
- Priority every cycle: FAULT > ESTOP > normal transitions.
- IDLE:
  - pending bit of current_floor set and floor_sensor valid: go to DOOR_OPEN.
  - Else, if a call is above and (dir_up=1 or no call below): go to MOVE_UP, dir_up=1.
  - Else, if a call is below: go to MOVE_DOWN, dir_up=0.
  - Else stay in IDLE with target_floor=0.
- target_floor is recomputed every cycle in the MOVE states and IDLE:
  - MOVE_UP: nearest pending floor above current_floor.
  - MOVE_DOWN: nearest pending floor below current_floor.
  - IDLE: the chosen floor.
- MOVE_UP (motor=01) / MOVE_DOWN (motor=10):
  - Sensor one-hot at floor f with pending[f]=1: motor=00 and enter DOOR_OPEN in the same edge. Intermediate calls are served.
  - Sensor at top floor in MOVE_UP, or at floor 1 in MOVE_DOWN: force stop to IDLE, even with no pending bit (end-of-travel guard).
  - Between floors: keep moving, even if pending in that direction empties.
- Motor latency: motor changes on the same edge that changes state. Combinational decision, registered output, so 1 cycle from sensor/call edge to motor.
- DOOR_OPEN:
  - Entry: door_open=1, pending[current_floor]=0, timer=DOOR_TICKS.
  - Timer decrements each cycle.
  - door_obstruct=1 or a same-floor call: reload the timer to DOOR_TICKS.
  - Timer reaching 0 with no reload that cycle: door_open=0, go to IDLE.
  - Direction preference is kept, so the next IDLE continues the sweep.
- ESTOP:
  - emergency_stop=1 in any non-FAULT state: next edge motor=00, door_open=0, timer cleared.
  - pending and current_floor are preserved; calls are still latched.
  - On release: go to IDLE, then re-arbitrate.
- FAULT: motor=00, door_open=0, fault=1, target_floor=0. Exit only by reset.
- Simultaneous events:
  - Emergency and arrival on the same cycle: ESTOP wins, and pending[f] is not cleared.
  - Calls above and below in IDLE: dir_up decides.
- Reset mid-move: immediate motor=00 and all state to reset values.

Test Plan:
1. Reset, sensor=0001, pulse call_req=0100 -> motor=01 the next cycle, target_floor=3. Sensor passes 0010 without stopping; at 0100 motor=00, door_open=1, pending=0000. door_open falls after 8 cycles.
2. At floor 1 moving up to 4 (pending=1000), assert call_req=0010 before sensor=0010 -> stop at 2 with door cycle, then resume motor=01 to 4. pending ends at 0000.
3. At floor 3 after an up sweep, pending=0011|1000 -> next move is up to 4 (dir_up kept), then down serving 2 and then 1.
4. In DOOR_OPEN, hold door_obstruct for 20 cycles -> door_open stays 1. Door closes DOOR_TICKS cycles after release; a same-floor call mid-dwell also extends it.
5. Moving down, assert emergency_stop -> motor=00 the next cycle and pending is retained. Release -> motor=10 resumes toward the same target.
6. Drive floor_sensor=0110 while moving -> fault=1, motor=00, calls are ignored. Only rst_n low clears fault.

Source files
------------

// File: rtl/elevator_scheduler.sv
// SCAN (collective-control) elevator scheduler: latches floor calls, picks the
// motor direction, sequences the door dwell and traps e-stop / sensor faults.
module elevator_scheduler #(
  parameter int N_FLOORS   = 4,
  parameter int DOOR_TICKS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_FLOORS-1:0] call_req,
  input  logic [N_FLOORS-1:0] floor_sensor,
  input  logic                door_obstruct,
  input  logic                emergency_stop,
  output logic [1:0]          motor,
  output logic                door_open,
  output logic [2:0]          current_floor,
  output logic [2:0]          target_floor,
  output logic [N_FLOORS-1:0] pending,
  output logic                fault
);
  localparam int TW = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] RELOAD = TW'(DOOR_TICKS);
  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_UP   = 2'b01;
  localparam logic [1:0] M_DOWN = 2'b10;

  typedef enum logic [2:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, ESTOP, FAULT} state_t;

  state_t              state, state_nx;
  logic [TW-1:0]       timer, timer_nx;
  logic                dir_up, dir_up_nx;
  logic [1:0]          motor_nx;
  logic                door_nx, fault_nx;
  logic [2:0]          floor_nx, target_nx;
  logic [N_FLOORS-1:0] pending_nx;

  logic                sensor_valid, sensor_multi;
  logic [2:0]          floor_now, near_up, near_dn;
  logic [N_FLOORS-1:0] cur_mask, calls_in, pend_all;
  logic                at_call, same_floor_call, enter_door;

  // Smallest pending floor strictly above f, or 0 when there is none.
  function automatic logic [2:0] nearest_above(input logic [N_FLOORS-1:0] p,
                                               input logic [2:0] f);
    logic [2:0] r;
    r = '0;
    for (int i = N_FLOORS; i >= 1; i--)
      if (i > int'(f) && p[i-1]) r = 3'(i);
    return r;
  endfunction

  function automatic logic [2:0] nearest_below(input logic [N_FLOORS-1:0] p,
                                               input logic [2:0] f);
    logic [2:0] r;
    r = '0;
    for (int i = 1; i <= N_FLOORS; i++)
      if (i < int'(f) && p[i-1]) r = 3'(i);
    return r;
  endfunction

  always_comb begin
    sensor_valid = $onehot(floor_sensor);
    sensor_multi = !$onehot0(floor_sensor);
    floor_now    = current_floor;
    for (int i = 0; i < N_FLOORS; i++)
      if (sensor_valid && floor_sensor[i]) floor_now = 3'(i + 1);
    cur_mask        = N_FLOORS'(1) << (current_floor - 3'd1);
    same_floor_call = |(call_req & cur_mask);
    // With the door already open, a call for this floor only extends the dwell.
    calls_in = call_req;
    if (state == DOOR_OPEN && !emergency_stop) calls_in = call_req & ~cur_mask;
    pend_all = pending | calls_in;
    at_call  = sensor_valid && |(pend_all & floor_sensor);
    near_up  = nearest_above(pend_all, floor_now);
    near_dn  = nearest_below(pend_all, floor_now);
  end

  always_comb begin
    state_nx   = state;
    motor_nx   = motor;
    door_nx    = door_open;
    timer_nx   = timer;
    dir_up_nx  = dir_up;
    target_nx  = target_floor;
    pending_nx = pend_all;
    fault_nx   = fault;
    floor_nx   = floor_now;
    enter_door = 1'b0;
    if (state == FAULT || sensor_multi) begin
      state_nx   = FAULT;
      motor_nx   = M_STOP;
      door_nx    = 1'b0;
      timer_nx   = '0;
      target_nx  = '0;
      fault_nx   = 1'b1;
      pending_nx = pending;
    end else if (emergency_stop) begin
      state_nx = ESTOP;
      motor_nx = M_STOP;
      door_nx  = 1'b0;
      timer_nx = '0;
    end else begin
      case (state)
        IDLE: begin
          if (at_call) begin
            enter_door = 1'b1;
            target_nx  = floor_now;
          end else if (near_up != 3'd0 && (dir_up || near_dn == 3'd0)) begin
            state_nx  = MOVE_UP;
            motor_nx  = M_UP;
            dir_up_nx = 1'b1;
            target_nx = near_up;
          end else if (near_dn != 3'd0) begin
            state_nx  = MOVE_DOWN;
            motor_nx  = M_DOWN;
            dir_up_nx = 1'b0;
            target_nx = near_dn;
          end else begin
            target_nx = '0;
          end
        end
        MOVE_UP: begin
          target_nx = near_up;
          if (at_call) begin
            enter_door = 1'b1;
          end else if (sensor_valid && floor_sensor[N_FLOORS-1]) begin
            state_nx = IDLE;
            motor_nx = M_STOP;
          end
        end
        MOVE_DOWN: begin
          target_nx = near_dn;
          if (at_call) begin
            enter_door = 1'b1;
          end else if (sensor_valid && floor_sensor[0]) begin
            state_nx = IDLE;
            motor_nx = M_STOP;
          end
        end
        DOOR_OPEN: begin
          if (door_obstruct || same_floor_call) begin
            timer_nx = RELOAD;
          end else if (timer <= TW'(1)) begin
            state_nx = IDLE;
            door_nx  = 1'b0;
            timer_nx = '0;
          end else begin
            timer_nx = timer - TW'(1);
          end
        end
        ESTOP: begin
          state_nx = IDLE;
          motor_nx = M_STOP;
        end
        default: ;
      endcase
      if (enter_door) begin
        state_nx   = DOOR_OPEN;
        motor_nx   = M_STOP;
        door_nx    = 1'b1;
        timer_nx   = RELOAD;
        pending_nx = pend_all & ~floor_sensor;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      motor         <= M_STOP;
      door_open     <= 1'b0;
      current_floor <= 3'd1;
      target_floor  <= '0;
      pending       <= '0;
      fault         <= 1'b0;
      dir_up        <= 1'b1;
      timer         <= '0;
    end else begin
      state         <= state_nx;
      motor         <= motor_nx;
      door_open     <= door_nx;
      current_floor <= floor_nx;
      target_floor  <= target_nx;
      pending       <= pending_nx;
      fault         <= fault_nx;
      dir_up        <= dir_up_nx;
      timer         <= timer_nx;
    end
  end
endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: a vector table for the basic trip, directed
// corner sequences, and random traffic on a simulated shaft vs. a floor model.
`timescale 1ns/1ps
module tb_elevator_scheduler;
  localparam int N     = 4;
  localparam int TICKS = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] call_req = '0;
  logic [N-1:0] floor_sensor = '0;
  logic         door_obstruct = 1'b0;
  logic         emergency_stop = 1'b0;
  logic [1:0]   motor;
  logic         door_open;
  logic [2:0]   current_floor;
  logic [2:0]   target_floor;
  logic [N-1:0] pending;
  logic         fault;

  int n_checks = 0;
  int n_pass   = 0;

  elevator_scheduler #(.N_FLOORS(N), .DOOR_TICKS(TICKS)) dut (
    .clk(clk), .rst_n(rst_n), .call_req(call_req), .floor_sensor(floor_sensor),
    .door_obstruct(door_obstruct), .emergency_stop(emergency_stop),
    .motor(motor), .door_open(door_open), .current_floor(current_floor),
    .target_floor(target_floor), .pending(pending), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Drive inputs just after a falling edge, then sample after the next one.
  task automatic cyc(input logic [N-1:0] c, input logic [N-1:0] s,
                     input logic ob = 1'b0, input logic es = 1'b0);
    call_req = c; floor_sensor = s; door_obstruct = ob; emergency_stop = es;
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [N-1:0] s);
    rst_n = 1'b0; call_req = '0; floor_sensor = s;
    door_obstruct = 1'b0; emergency_stop = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic expect_out(input string tag, input int m, input int d,
                            input int cf, input int tf, input int p);
    check({tag, " motor"}, motor, m);
    check({tag, " door"}, door_open, d);
    if (cf >= 0) check({tag, " cur"}, current_floor, cf);
    if (tf >= 0) check({tag, " tgt"}, target_floor, tf);
    if (p >= 0) check({tag, " pend"}, pending, p);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] call;
    logic [N-1:0] sensor;
    int motor, door, cur, tgt, pend;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic [N-1:0] c, input logic [N-1:0] s,
                     input int m, input int d, input int cf, input int tf, input int p);
    vec_t v;
    v.call = c; v.sensor = s; v.motor = m; v.door = d; v.cur = cf; v.tgt = tf; v.pend = p;
    tbl.push_back(v);
  endtask

  // ---------------- reference model ----------------
  localparam int S_IDLE = 0, S_UP = 1, S_DN = 2, S_DOOR = 3, S_STOP = 4, S_FAULT = 5;
  int m_state, m_floor, m_target, m_timer, m_motor;
  bit m_door, m_fault, m_up;
  bit m_pend [1:N];

  function automatic int pend_word();
    int w = 0;
    for (int f = 1; f <= N; f++) if (m_pend[f]) w += (1 << (f - 1));
    return w;
  endfunction

  task automatic model_reset();
    m_state = S_IDLE; m_floor = 1; m_target = 0; m_timer = 0; m_motor = 0;
    m_door = 0; m_fault = 0; m_up = 1;
    for (int f = 1; f <= N; f++) m_pend[f] = 0;
  endtask

  task automatic model_open(input int f);
    m_state = S_DOOR; m_motor = 0; m_door = 1; m_timer = TICKS; m_pend[f] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] c, input logic [N-1:0] s, input bit ob, input bit es);
    int hits = 0, at = 0, here, up = 0, dn = 0;
    bit reload;
    for (int f = 1; f <= N; f++) if (s[f-1]) begin hits++; at = f; end
    here = (hits == 1) ? at : m_floor;
    if (m_state == S_FAULT || hits > 1) begin
      m_state = S_FAULT; m_motor = 0; m_door = 0; m_fault = 1; m_target = 0; m_timer = 0;
      m_floor = here;
      return;
    end
    reload = ob || c[m_floor-1];
    for (int f = 1; f <= N; f++)
      if (c[f-1] && !(m_state == S_DOOR && !es && f == m_floor)) m_pend[f] = 1;
    for (int d = N - 1; d >= 1; d--) begin
      if (here + d <= N && m_pend[here + d]) up = here + d;
      if (here - d >= 1 && m_pend[here - d]) dn = here - d;
    end
    m_floor = here;
    if (es) begin
      m_state = S_STOP; m_motor = 0; m_door = 0; m_timer = 0;
      return;
    end
    case (m_state)
      S_STOP: begin m_state = S_IDLE; m_motor = 0; end
      S_IDLE: begin
        if (hits == 1 && m_pend[here]) begin model_open(here); m_target = here; end
        else if (up != 0 && (m_up || dn == 0)) begin m_state = S_UP; m_motor = 1; m_up = 1; m_target = up; end
        else if (dn != 0) begin m_state = S_DN; m_motor = 2; m_up = 0; m_target = dn; end
        else m_target = 0;
      end
      S_UP: begin
        m_target = up;
        if (hits == 1 && m_pend[here]) model_open(here);
        else if (hits == 1 && here == N) begin m_state = S_IDLE; m_motor = 0; end
      end
      S_DN: begin
        m_target = dn;
        if (hits == 1 && m_pend[here]) model_open(here);
        else if (hits == 1 && here == 1) begin m_state = S_IDLE; m_motor = 0; end
      end
      S_DOOR: begin
        if (reload) m_timer = TICKS;
        else if (m_timer <= 1) begin m_state = S_IDLE; m_door = 0; m_timer = 0; end
        else m_timer--;
      end
      default: ;
    endcase
  endtask

  task automatic compare_model(input int k);
    int act, exp_v;
    act   = {motor, door_open, current_floor, target_floor, pending, fault};
    exp_v = (m_motor << 12) | (int'(m_door) << 11) | (m_floor << 8) | (m_target << 5)
          | (pend_word() << 1) | int'(m_fault);
    n_checks++;
    if (act == exp_v) n_pass++;
    else $display("FAIL rand%0d outputs: got m=%0d d=%0d cur=%0d tgt=%0d pend=%b flt=%0d, expected m=%0d d=%0d cur=%0d tgt=%0d pend=%b flt=%0d",
                  k, motor, door_open, current_floor, target_floor, pending, fault,
                  m_motor, m_door, m_floor, m_target, pend_word(), m_fault);
  endtask

  // Shaft position in quarter-floor steps; a sensor bit is lit only at a landing.
  task automatic run_random(input int cycles, input int glitch_rate);
    int pos = 0;
    logic [N-1:0] c, s;
    bit ob, es;
    model_reset();
    do_reset(4'b0001);
    for (int k = 0; k < cycles; k++) begin
      compare_model(k);
      if (m_motor == 1 && pos < (N - 1) * 4) pos++;
      else if (m_motor == 2 && pos > 0) pos--;
      s = (pos % 4 == 0) ? (N'(1) << (pos / 4)) : '0;
      if (glitch_rate != 0 && $urandom_range(glitch_rate - 1) == 0)
        s = N'(3) << $urandom_range(N - 2);
      c  = ($urandom_range(5) == 0) ? N'($urandom) : '0;
      ob = ($urandom_range(9) == 0);
      es = ($urandom_range(39) == 0);
      model_step(c, s, ob, es);
      cyc(c, s, ob, es);
    end
    compare_model(cycles);
  endtask

  initial begin
    // Basic trip 1 -> 3, passing 2, with an 8-cycle dwell.
    add(4'b0000, 4'b0001, 0, 0, 1, 0, 4'b0000);
    add(4'b0100, 4'b0001, 1, 0, 1, 3, 4'b0100);
    add(4'b0000, 4'b0000, 1, 0, 1, 3, 4'b0100);
    add(4'b0000, 4'b0010, 1, 0, 2, 3, 4'b0100);
    add(4'b0000, 4'b0000, 1, 0, 2, 3, 4'b0100);
    add(4'b0000, 4'b0100, 0, 1, 3, 0, 4'b0000);
    for (int i = 0; i < TICKS - 1; i++) add(4'b0000, 4'b0100, 0, 1, 3, 0, 4'b0000);
    add(4'b0000, 4'b0100, 0, 0, 3, 0, 4'b0000);
    add(4'b0000, 4'b0100, 0, 0, 3, 0, 4'b0000);

    do_reset(4'b0001);
    expect_out("reset", 0, 0, 1, 0, 0);
    check("reset fault", fault, 0);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].call, tbl[i].sensor);
      expect_out($sformatf("vec%0d", i), tbl[i].motor, tbl[i].door, tbl[i].cur, tbl[i].tgt, tbl[i].pend);
    end

    // Intermediate call picked up on the way to the top floor.
    do_reset(4'b0001);
    cyc(4'b1000, 4'b0001); expect_out("t2 start", 1, 0, 1, 4, 4'b1000);
    cyc(4'b0010, 4'b0000); expect_out("t2 call2", 1, 0, 1, 2, 4'b1010);
    cyc(4'b0000, 4'b0010); expect_out("t2 stop2", 0, 1, 2, 4, 4'b1000);
    repeat (TICKS - 1) cyc(4'b0000, 4'b0010);
    check("t2 dwell door", door_open, 1);
    cyc(4'b0000, 4'b0010); expect_out("t2 closed", 0, 0, 2, -1, 4'b1000);
    cyc(4'b0000, 4'b0010); expect_out("t2 resume", 1, 0, 2, 4, 4'b1000);
    cyc(4'b0000, 4'b0000); cyc(4'b0000, 4'b0100); cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b1000); expect_out("t2 top", 0, 1, 4, 0, 4'b0000);

    // Sweep continues upward before reversing.
    do_reset(4'b0001);
    cyc(4'b0100, 4'b0001); cyc(4'b0000, 4'b0100);
    expect_out("t3 at3", 0, 1, 3, 0, 4'b0000);
    cyc(4'b1011, 4'b0100); expect_out("t3 calls", 0, 1, 3, -1, 4'b1011);
    repeat (TICKS - 2) cyc(4'b0000, 4'b0100);
    cyc(4'b0000, 4'b0100); check("t3 closed", door_open, 0);
    cyc(4'b0000, 4'b0100); expect_out("t3 up", 1, 0, 3, 4, 4'b1011);
    cyc(4'b0000, 4'b0000); cyc(4'b0000, 4'b1000);
    expect_out("t3 at4", 0, 1, 4, 0, 4'b0011);
    repeat (TICKS) cyc(4'b0000, 4'b1000);
    cyc(4'b0000, 4'b1000); expect_out("t3 down", 2, 0, 4, 2, 4'b0011);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0100); expect_out("t3 pass3", 2, 0, 3, 2, 4'b0011);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0010); expect_out("t3 at2", 0, 1, 2, 1, 4'b0001);
    repeat (TICKS) cyc(4'b0000, 4'b0010);
    cyc(4'b0000, 4'b0010); expect_out("t3 down1", 2, 0, 2, 1, 4'b0001);
    cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0001); expect_out("t3 at1", 0, 1, 1, 0, 4'b0000);

    // Obstruction and same-floor call both hold the door.
    do_reset(4'b0001);
    cyc(4'b0001, 4'b0001); expect_out("t4 open", 0, 1, 1, 1, 4'b0000);
    repeat (20) cyc(4'b0000, 4'b0001, 1'b1);
    check("t4 obstructed", door_open, 1);
    repeat (TICKS - 1) cyc(4'b0000, 4'b0001);
    check("t4 before close", door_open, 1);
    cyc(4'b0000, 4'b0001); check("t4 after close", door_open, 0);
    cyc(4'b0001, 4'b0001); check("t4 reopen", door_open, 1);
    repeat (3) cyc(4'b0000, 4'b0001);
    cyc(4'b0001, 4'b0001); check("t4 call not latched", pending, 0);
    repeat (TICKS - 1) cyc(4'b0000, 4'b0001);
    check("t4 extended", door_open, 1);
    cyc(4'b0000, 4'b0001); check("t4 extended close", door_open, 0);

    // Emergency stop while moving down, including arrival under e-stop.
    do_reset(4'b0001);
    cyc(4'b0000, 4'b0100);
    cyc(4'b0001, 4'b0100); expect_out("t5 down", 2, 0, 3, 1, 4'b0001);
    cyc(4'b0000, 4'b0000, 1'b0, 1'b1); expect_out("t5 estop", 0, 0, 3, -1, 4'b0001);
    cyc(4'b1000, 4'b0000, 1'b0, 1'b1); check("t5 latch in estop", pending, 4'b1001);
    cyc(4'b0000, 4'b0000); check("t5 release motor", motor, 0);
    cyc(4'b0000, 4'b0000); expect_out("t5 resume", 2, 0, 3, 1, 4'b1001);
    cyc(4'b0000, 4'b0010); cyc(4'b0000, 4'b0000);
    cyc(4'b0000, 4'b0001, 1'b0, 1'b1); expect_out("t5 arrive estop", 0, 0, 1, -1, 4'b1001);
    cyc(4'b0000, 4'b0001);
    cyc(4'b0000, 4'b0001); expect_out("t5 serve1", 0, 1, 1, 1, 4'b1000);

    // Sensor fault is sticky until reset.
    do_reset(4'b0001);
    cyc(4'b1000, 4'b0001); check("t6 moving", motor, 1);
    cyc(4'b0000, 4'b0110);
    check("t6 fault", fault, 1);
    expect_out("t6 halted", 0, 0, -1, 0, 4'b1000);
    cyc(4'b0100, 4'b0100); cyc(4'b0000, 4'b0001);
    check("t6 sticky", fault, 1);
    check("t6 ignored call", pending, 4'b1000);
    rst_n = 1'b0; #1;
    check("t6 reset clears", fault, 0);

    // Asynchronous reset in mid-move.
    do_reset(4'b0001);
    cyc(4'b1000, 4'b0001); check("rst moving", motor, 1);
    cyc(4'b0000, 4'b0000);
    rst_n = 1'b0; #1;
    expect_out("rst midmove", 0, 0, 1, 0, 0);

    for (int r = 0; r < 3; r++) run_random(600, 0);
    run_random(400, 300);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", n_checks);
    $fatal(1, "timeout");
  end
endmodule
